// File: rtl/fg_sweep_ctrl.sv
// Linear frequency-sweep sequencer feeding set_count/duty_cycle/sig_type of the function generator.
// A host loads a descriptor over valid/ready, then start steps the count toward stop once or in a loop.
module fg_sweep_ctrl #(
  parameter int unsigned CNT_W     = 32,
  parameter int unsigned LIM_TABLE = 9999,
  parameter int unsigned LIM_PULSE = 499999
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cfg_valid,
  output logic             cfg_ready,
  input  logic [1:0]       cfg_sig_type,
  input  logic [7:0]       cfg_duty,
  input  logic [CNT_W-1:0] cfg_start,
  input  logic [CNT_W-1:0] cfg_stop,
  input  logic [CNT_W-1:0] cfg_step,
  input  logic [CNT_W-1:0] cfg_dwell,
  input  logic             cfg_loop,
  input  logic             start,
  input  logic             abort,
  input  logic             pause,
  output logic [CNT_W-1:0] set_count,
  output logic [7:0]       duty_cycle,
  output logic [1:0]       sig_type,
  output logic             busy,
  output logic             done,
  output logic             step_tick,
  output logic             cfg_err
);

  localparam logic [CNT_W-1:0] LimTable   = CNT_W'(LIM_TABLE);
  localparam logic [CNT_W-1:0] LimPulse   = CNT_W'(LIM_PULSE);
  localparam logic [CNT_W-1:0] ResetCount = CNT_W'(999);
  localparam logic [CNT_W-1:0] One        = CNT_W'(1);

  typedef enum logic [1:0] {StIdle, StRun, StPause} state_e;

  state_e           state;
  logic             armed;
  logic [1:0]       sh_type;
  logic [7:0]       sh_duty;
  logic [CNT_W-1:0] sh_start, sh_stop, sh_step, sh_dwell;
  logic             sh_loop;
  logic [CNT_W-1:0] dwell_cnt;

  logic [CNT_W-1:0] lim;
  logic             desc_ok;
  logic             dir_up;
  logic [CNT_W:0]   gap;
  logic [CNT_W-1:0] next_count;

  assign cfg_ready = (state == StIdle);
  assign busy      = (state != StIdle);

  always_comb begin
    lim     = cfg_sig_type[1] ? LimPulse : LimTable;
    desc_ok = (cfg_start <= lim) && (cfg_stop <= lim) && (cfg_step != '0) && (cfg_dwell != '0);
  end

  // The distance to stop is taken one bit wider; stepping only happens when that distance exceeds
  // the step, so the plain-width add/subtract below can neither overshoot nor wrap.
  always_comb begin
    dir_up = (sh_stop >= sh_start);
    if (dir_up) begin
      gap = {1'b0, sh_stop} - {1'b0, set_count};
    end else begin
      gap = {1'b0, set_count} - {1'b0, sh_stop};
    end
    if (gap <= {1'b0, sh_step}) begin
      next_count = sh_stop;
    end else if (dir_up) begin
      next_count = set_count + sh_step;
    end else begin
      next_count = set_count - sh_step;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= StIdle;
      armed      <= 1'b0;
      cfg_err    <= 1'b0;
      sh_type    <= '0;
      sh_duty    <= '0;
      sh_start   <= '0;
      sh_stop    <= '0;
      sh_step    <= '0;
      sh_dwell   <= '0;
      sh_loop    <= 1'b0;
      dwell_cnt  <= '0;
      set_count  <= ResetCount;
      duty_cycle <= '0;
      sig_type   <= '0;
      done       <= 1'b0;
      step_tick  <= 1'b0;
    end else begin
      done      <= 1'b0;
      step_tick <= 1'b0;
      case (state)
        StIdle: begin
          if (cfg_valid) begin
            if (desc_ok) begin
              sh_type  <= cfg_sig_type;
              sh_duty  <= cfg_duty;
              sh_start <= cfg_start;
              sh_stop  <= cfg_stop;
              sh_step  <= cfg_step;
              sh_dwell <= cfg_dwell;
              sh_loop  <= cfg_loop;
              armed    <= 1'b1;
              cfg_err  <= 1'b0;
            end else begin
              cfg_err  <= 1'b1;
            end
          end
          if (start && armed && !abort) begin
            sig_type   <= sh_type;
            duty_cycle <= sh_duty;
            set_count  <= sh_start;
            dwell_cnt  <= sh_dwell - One;
            state      <= StRun;
          end
        end
        StRun, StPause: begin
          if (abort) begin
            state <= StIdle;
          end else if (pause) begin
            state <= StPause;
          end else begin
            // Leaving PAUSE counts as a normal RUN cycle.
            state <= StRun;
            if (dwell_cnt != '0) begin
              dwell_cnt <= dwell_cnt - One;
            end else if (set_count != sh_stop) begin
              set_count <= next_count;
              step_tick <= 1'b1;
              dwell_cnt <= sh_dwell - One;
            end else if (sh_loop) begin
              set_count <= sh_start;
              step_tick <= 1'b1;
              dwell_cnt <= sh_dwell - One;
            end else begin
              state <= StIdle;
              done  <= 1'b1;
            end
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_fg_sweep_ctrl.sv
// Bench for fg_sweep_ctrl: list-based sweep model checked every cycle, plus literal scenario checks.
module tb_fg_sweep_ctrl;

  localparam int CW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          cfg_valid = 1'b0;
  logic          cfg_ready;
  logic [1:0]    cfg_sig_type = '0;
  logic [7:0]    cfg_duty = '0;
  logic [CW-1:0] cfg_start = '0, cfg_stop = '0, cfg_step = '0, cfg_dwell = '0;
  logic          cfg_loop = 1'b0;
  logic          start = 1'b0, abort = 1'b0, pause = 1'b0;
  logic [CW-1:0] set_count;
  logic [7:0]    duty_cycle;
  logic [1:0]    sig_type;
  logic          busy, done, step_tick, cfg_err;

  always #5 clk = ~clk;

  fg_sweep_ctrl dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_sig_type (cfg_sig_type),
    .cfg_duty     (cfg_duty),
    .cfg_start    (cfg_start),
    .cfg_stop     (cfg_stop),
    .cfg_step     (cfg_step),
    .cfg_dwell    (cfg_dwell),
    .cfg_loop     (cfg_loop),
    .start        (start),
    .abort        (abort),
    .pause        (pause),
    .set_count    (set_count),
    .duty_cycle   (duty_cycle),
    .sig_type     (sig_type),
    .busy         (busy),
    .done         (done),
    .step_tick    (step_tick),
    .cfg_err      (cfg_err)
  );

  int n_chk = 0;
  int n_err = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input longint unsigned act, input longint unsigned exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a sweep is the list of values it visits; each is held for dwell unpaused busy cycles.
  bit              m_busy, m_armed, m_err, m_done, m_tick;
  longint unsigned m_count, m_duty, m_type;
  longint unsigned s_type, s_duty, s_dwell;
  bit              s_loop;
  longint unsigned vals[$];
  int              m_idx, m_held;

  function automatic void m_reset();
    m_busy = 0; m_armed = 0; m_err = 0; m_done = 0; m_tick = 0;
    m_count = 999; m_duty = 0; m_type = 0;
  endfunction

  function automatic void m_step();
    longint unsigned lim, v, a, b, st;
    m_done = 0;
    m_tick = 0;
    if (!m_busy) begin
      if (start && !abort && m_armed) begin
        m_type = s_type; m_duty = s_duty; m_idx = 0; m_count = vals[0]; m_held = 0; m_busy = 1;
      end
      if (cfg_valid) begin
        lim = (cfg_sig_type >= 2) ? 499999 : 9999;
        a = cfg_start; b = cfg_stop; st = cfg_step;
        if (a <= lim && b <= lim && st != 0 && cfg_dwell != 0) begin
          s_type = cfg_sig_type; s_duty = cfg_duty; s_dwell = cfg_dwell; s_loop = cfg_loop;
          vals.delete();
          v = a;
          vals.push_back(v);
          while (v != b) begin
            if (b >= a) v = (b - v <= st) ? b : v + st;
            else        v = (v - b <= st) ? b : v - st;
            vals.push_back(v);
          end
          m_armed = 1; m_err = 0;
        end else begin
          m_err = 1;
        end
      end
    end else if (abort) begin
      m_busy = 0;
    end else if (!pause) begin
      m_held++;
      if (m_held == s_dwell) begin
        m_held = 0;
        if (m_idx + 1 < vals.size()) begin
          m_idx++; m_count = vals[m_idx]; m_tick = 1;
        end else if (s_loop) begin
          m_idx = 0; m_count = vals[0]; m_tick = 1;
        end else begin
          m_busy = 0; m_done = 1;
        end
      end
    end
  endfunction

  initial begin
    m_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) m_reset();
      else        m_step();
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (chk_en && rst_n) begin
        chk("m_set_count", set_count, m_count);
        chk("m_duty", duty_cycle, m_duty);
        chk("m_type", sig_type, m_type);
        chk("m_busy", busy, m_busy);
        chk("m_ready", cfg_ready, !m_busy);
        chk("m_done", done, m_done);
        chk("m_tick", step_tick, m_tick);
        chk("m_err", cfg_err, m_err);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_desc(input logic [1:0] ty, input logic [7:0] du, input logic [CW-1:0] s0,
                           input logic [CW-1:0] s1, input logic [CW-1:0] st,
                           input logic [CW-1:0] dw, input logic lp);
    cfg_sig_type = ty; cfg_duty = du; cfg_start = s0; cfg_stop = s1;
    cfg_step = st; cfg_dwell = dw; cfg_loop = lp;
    cfg_valid = 1'b1;
    tick();
    cfg_valid = 1'b0;
  endtask

  task automatic do_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  int exp_c[4] = '{100, 110, 120, 125};
  int exp_d[3] = '{1000, 700, 400};

  initial begin
    int ticks;
    int unsigned ty, lim, a, b, diff, stp, dw, r;

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk_en = 1'b1;
    @(negedge clk);
    chk("rst_count", set_count, 999);
    chk("rst_duty", duty_cycle, 0);
    chk("rst_type", sig_type, 0);
    chk("rst_busy", busy, 0);
    chk("rst_ready", cfg_ready, 1);
    chk("rst_err", cfg_err, 0);

    // Validation while unarmed
    send_desc(2'd0, 8'h40, 100, 10000, 10, 4, 1'b0);
    @(negedge clk) chk("rej_limit", cfg_err, 1);
    do_start();
    @(negedge clk);
    chk("unarmed_busy", busy, 0);
    chk("unarmed_count", set_count, 999);
    send_desc(2'd2, 8'h80, 0, 499999, 100000, 3, 1'b0);
    @(negedge clk) chk("acc_pulse_lim", cfg_err, 0);
    send_desc(2'd1, 8'h00, 5, 6, 0, 1, 1'b0);
    @(negedge clk) chk("rej_step0", cfg_err, 1);

    // Up sweep
    send_desc(2'd0, 8'h20, 100, 130, 10, 4, 1'b0);
    do_start();
    ticks = 0;
    for (int j = 0; j < 16; j++) begin
      @(negedge clk);
      chk("up_val", set_count, 100 + 10 * (j / 4));
      ticks += int'(step_tick);
    end
    chk("up_duty", duty_cycle, 8'h20);
    @(negedge clk);
    chk("up_done", done, 1);
    chk("up_busy", busy, 0);
    chk("up_ticks", ticks, 3);
    @(negedge clk) chk("up_done_once", done, 0);

    // Clamp
    send_desc(2'd1, 8'h10, 100, 125, 10, 2, 1'b0);
    do_start();
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      chk("clamp_val", set_count, exp_c[j / 2]);
    end
    @(negedge clk) chk("clamp_done", done, 1);

    // Down loop, aborted at 700
    send_desc(2'd2, 8'h55, 1000, 400, 300, 2, 1'b1);
    do_start();
    for (int j = 0; j < 9; j++) begin
      @(negedge clk);
      chk("down_val", set_count, exp_d[(j / 2) % 3]);
    end
    chk("down_type", sig_type, 2);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_count", set_count, 700);
    chk("abort_no_done", done, 0);

    // start+abort in IDLE
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    @(negedge clk);
    chk("start_abort_idle", busy, 0);
    chk("start_abort_cnt", set_count, 700);

    // Pause for 5 edges inside a dwell of 4
    send_desc(2'd0, 8'h7f, 100, 130, 10, 4, 1'b0);
    do_start();
    tick();
    pause = 1'b1;
    repeat (5) tick();
    chk("pause_busy", busy, 1);
    pause = 1'b0;
    for (int j = 6; j < 9; j++) begin
      @(negedge clk);
      chk("pause_hold", set_count, 100);
    end
    @(negedge clk) chk("pause_next", set_count, 110);
    start = 1'b1;
    tick();
    start = 1'b0;
    @(negedge clk) chk("run_start_ignored", set_count, 110);
    abort = 1'b1;
    tick();
    abort = 1'b0;

    // Asynchronous reset mid-sweep
    do_start();
    repeat (5) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_count", set_count, 999);
    chk("arst_duty", duty_cycle, 0);
    chk("arst_busy", busy, 0);
    @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    do_start();
    @(negedge clk) chk("arst_disarmed", busy, 0);

    // Randomized sweeps with pause/start/abort/cfg noise
    for (int t = 0; t < 40; t++) begin
      ty = $urandom_range(0, 3);
      lim = (ty >= 2) ? 499999 : 9999;
      a = $urandom_range(0, lim);
      b = ($urandom_range(0, 3) == 0) ? a : $urandom_range(0, lim);
      if ($urandom_range(0, 7) == 0) b = lim;
      diff = (a > b) ? a - b : b - a;
      stp = diff / 6 + 1 + $urandom_range(0, diff / 4 + 3);
      dw = $urandom_range(1, 4);
      r = $urandom_range(0, 9);
      if (r == 0) stp = 0;
      if (r == 1) dw = 0;
      if (r == 2) a = lim + 1 + $urandom_range(0, 5);
      send_desc(2'(ty), 8'($urandom), a, b, stp, dw, 1'($urandom_range(0, 1)));
      do_start();
      repeat (60) begin
        pause = ($urandom_range(0, 3) == 0);
        start = ($urandom_range(0, 9) == 0);
        abort = ($urandom_range(0, 39) == 0);
        cfg_valid = !start && ($urandom_range(0, 7) == 0);
        tick();
      end
      pause = 1'b0; start = 1'b0; cfg_valid = 1'b0;
      abort = 1'b1;
      tick();
      abort = 1'b0;
      tick();
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
